pipeline_sink: RTL and testbench
================================

# pipeline_sink

Synchronous receiver at the right end of the asynchronous controller pipeline. It answers the last stage's 4-phase bundled-data request channel (Rreq/Rack) and buffers accepted words in a FIFO for clocked logic downstream. When a word fails its parity check, the block drops the word and raises the error channel (REreq/REack) toward the last stage as initiator.

## Interface
- DATA_WIDTH, 8, payload width excluding parity
- DEPTH, 4, FIFO entries, power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops on each asynchronous input, ≥2
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- Rreq  in  1  async request from last pipeline stage
- Rdata  in  DATA_WIDTH  bundled data, stable while Rreq=1
- Rpar  in  1  even parity over Rdata, bundled with Rdata
- Rack  out  1  acknowledge to last stage, registered
- REreq  out  1  error request to last stage, registered
- REack  in  1  async error acknowledge from last stage
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_WIDTH  FIFO head word
- out_ready  in  1  downstream consumes head when out_valid&out_ready
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- err_count  out  8  dropped-word count, saturating at 255

## Operation
- Rreq and REack each pass through a SYNC_STAGES flop chain, giving req_s and eack_s. Rdata and Rpar are not synchronized. They are sampled only after req_s=1, which is safe because they are bundled.
- FSM states:
  - IDLE: Rack=0, REreq=0. When req_s=1 and the FIFO is not full, sample Rdata/Rpar. If parity is good (^{Rdata,Rpar}==0), push Rdata to the FIFO. If parity is bad, increment err_count and set the err_pend flag. Either way, go to ACK. When req_s=1 and the FIFO is full, stay in IDLE and do not sample.
  - ACK: Rack=1. When req_s=0: go to EREQ if err_pend is set, otherwise go to IDLE.
  - EREQ: REreq=1. When eack_s=1, go to EREL.
  - EREL: REreq=0. When eack_s=0, clear err_pend and go to IDLE.
- FIFO:
  - Circular buffer, write pointer and read pointer each one bit wider than log2(DEPTH). Pointers wrap at DEPTH.
  - full = MSBs differ and the other bits are equal. empty = pointers equal.
  - Pop on out_valid&out_ready. out_data is the head entry and stays stable while out_valid=1 and no pop occurs.
  - Simultaneous push and pop are both performed; level is unchanged.
  - A pop in the same cycle as full frees a slot. The IDLE accept waits until the next cycle, because the full flag is registered.
- While the FSM is outside IDLE, a new Rreq rising edge cannot occur, because the 4-phase protocol forbids it. The block does not check for this.

## Timing
- Reset values: Rack=0, REreq=0, out_valid=0, out_data=0, level=0, err_count=0, FSM=IDLE, pointers=0, synchronizer flops=0, err_pend=0.
- Rreq rise to Rack rise: SYNC_STAGES+1 clk edges when the FIFO is not full.
- Rreq fall to Rack fall: SYNC_STAGES+1 edges, or the error handshake follows instead.
- Push to out_valid=1: 1 edge after the capture edge. level updates on the same edge as out_valid.
- Error path timing:
  - REreq rises 1 edge after Rack falls.
  - REreq falls SYNC_STAGES+1 edges after REack rises.
  - Return to IDLE takes SYNC_STAGES+1 edges after REack falls.
- Reset mid-handshake: all outputs drop immediately (asynchronously) and the FIFO is emptied. If Rreq is still 1 after reset release, it is treated as a new request and resampled.
- err_count holds at 255 and does not wrap.

## Test plan
- Reset release, DEPTH=4, SYNC_STAGES=2; single handshake with Rdata=0xA5, Rpar=0. Required: Rack=1 exactly 3 edges after Rreq rises; out_valid=1 and out_data=0xA5 on the following edge; level=1; Rack=0 3 edges after Rreq falls.
- out_ready=0; five handshakes with data 1,2,3,4,5 (correct parity). Required: level=4 and the fifth Rreq is not acked. Then pulse out_ready for 1 cycle. Required: 1 pops, 5 is accepted, and the sequence drains in order as 2,3,4,5.
- Bad parity (Rdata=0x01, Rpar=0). Required: Rack handshake completes; no push (level=0); err_count=1; REreq=1 one edge after Rack falls. Drive REack up then down. Required: REreq=0 3 edges after REack rises; FSM back in IDLE and the next good word is accepted.
- Continuous traffic of 10 good words with out_ready=1 throughout. Required: words out in order, level never exceeds 2, simultaneous push and pop leave level unchanged, pointers wrap cleanly past DEPTH.
- Assert rst while in ACK with 2 words buffered. Required: Rack=0, out_valid=0, level=0 immediately. Keep Rreq=1 through reset release. Required: the word is re-accepted after 3 edges.
- 256 bad-parity words. Required: err_count saturates at 255.

Source files
------------

// File: rtl/pipeline_sink.sv
// pipeline_sink: clocked receiver at the tail of the asynchronous pipeline.
// Completes the 4-phase Rreq/Rack handshake, parity-checks each word, buffers
// good words in a small FIFO and reports bad words over the REreq/REack channel.
module pipeline_sink #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         Rreq,
   input  logic [DATA_WIDTH-1:0]        Rdata,
   input  logic                         Rpar,
   output logic                         Rack,
   output logic                         REreq,
   input  logic                         REack,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [7:0]                   err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      EREQ,
      EREL
   } state_t;

   state_t state;
   state_t next_state;

   logic [SYNC_STAGES-1:0] req_sync;
   logic [SYNC_STAGES-1:0] eack_sync;
   logic                   req_s;
   logic                   eack_s;

   logic                   accept;
   logic                   par_ok;
   logic                   rack_d;
   logic                   ereq_d;
   logic                   clear_err;
   logic                   err_pend;

   logic                   push_pend;
   logic [DATA_WIDTH-1:0]  push_data;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [PW-1:0]          wptr;
   logic [PW-1:0]          rptr;
   logic                   full;
   logic                   pop;

   assign req_s  = req_sync[SYNC_STAGES-1];
   assign eack_s = eack_sync[SYNC_STAGES-1];

   // Even parity over data plus parity bit; any odd total marks a corrupted word.
   assign par_ok = ~(^{Rdata, Rpar});

   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign out_valid = (wptr != rptr);
   assign pop       = out_valid && out_ready;
   assign level     = LW'(wptr - rptr);
   assign out_data  = out_valid ? mem[rptr[AW-1:0]] : '0;

   // Bring the two asynchronous handshake inputs into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_sync  <= '0;
         eack_sync <= '0;
      end else begin
         req_sync  <= {req_sync[SYNC_STAGES-2:0], Rreq};
         eack_sync <= {eack_sync[SYNC_STAGES-2:0], REack};
      end
   end

   // State register, with the handshake outputs registered alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         Rack  <= 1'b0;
         REreq <= 1'b0;
      end else begin
         state <= next_state;
         Rack  <= rack_d;
         REreq <= ereq_d;
      end
   end

   // Next-state logic; a request is only taken when there is room to store it.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req_s && !full) begin
               accept     = 1'b1;
               next_state = ACK;
            end
         end
         ACK: begin
            if (!req_s) begin
               next_state = err_pend ? EREQ : IDLE;
            end
         end
         EREQ: begin
            if (eack_s) begin
               next_state = EREL;
            end
         end
         EREL: begin
            if (!eack_s) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode; REreq waits one cycle in EREQ so it rises after Rack has dropped.
   always_comb begin
      rack_d    = (next_state == ACK);
      ereq_d    = (state == EREQ) && (next_state == EREQ);
      clear_err = (state == EREL) && (next_state == IDLE);
   end

   // Capture an accepted word: stage good data for the FIFO, count and flag bad data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_pend <= 1'b0;
         push_data <= '0;
         err_pend  <= 1'b0;
         err_count <= 8'd0;
      end else begin
         push_pend <= accept && par_ok;
         if (accept && par_ok) begin
            push_data <= Rdata;
         end
         if (accept && !par_ok) begin
            err_pend <= 1'b1;
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end else if (clear_err) begin
            err_pend <= 1'b0;
         end
      end
   end

   // FIFO pointers; the extra MSB tells a full buffer apart from an empty one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_pend) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
      end
   end

   // FIFO storage; contents need no reset because out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (push_pend) begin
         mem[wptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: tb/tb_pipeline_sink.sv
// tb_pipeline_sink: directed bench for pipeline_sink (DEPTH=4, SYNC_STAGES=2)
// with hand-computed expectations checked by immediate assertions.
module tb_pipeline_sink;

   logic       clk;
   logic       rst;
   logic       Rreq;
   logic [7:0] Rdata;
   logic       Rpar;
   logic       Rack;
   logic       REreq;
   logic       REack;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] level;
   logic [7:0] err_count;

   int checks;
   int errors;

   pipeline_sink #(
      .DATA_WIDTH (8),
      .DEPTH      (4),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .Rreq     (Rreq),
      .Rdata    (Rdata),
      .Rpar     (Rpar),
      .Rack     (Rack),
      .REreq    (REreq),
      .REack    (REack),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .level    (level),
      .err_count(err_count)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic goodPar(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic applyStimulus(input logic req, input logic [7:0] data, input logic par);
      Rreq  = req;
      Rdata = data;
      Rpar  = par;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitRack(input logic val, input string tag);
      int n = 0;
      while (Rack !== val && n < 20) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'd0, Rack}, {31'd0, val});
   endtask

   task automatic waitEreq(input logic val, input string tag);
      int n = 0;
      while (REreq !== val && n < 20) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'd0, REreq}, {31'd0, val});
   endtask

   task automatic handshake(input logic [7:0] data, input logic par);
      applyStimulus(1'b1, data, par);
      waitRack(1'b1, "hs_ack_rise");
      applyStimulus(1'b0, data, par);
      waitRack(1'b0, "hs_ack_fall");
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [7:0] w;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      REack     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      tick();

      checkOutput("rst_rack", {31'd0, Rack}, 32'd0);
      checkOutput("rst_ereq", {31'd0, REreq}, 32'd0);
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_data", {24'd0, out_data}, 32'd0);
      checkOutput("rst_level", {29'd0, level}, 32'd0);
      checkOutput("rst_errcnt", {24'd0, err_count}, 32'd0);
      rst = 1'b0;

      // single handshake 0xA5
      applyStimulus(1'b1, 8'hA5, 1'b0);
      tick();
      tick();
      checkOutput("t1_rack_edge2", {31'd0, Rack}, 32'd0);
      tick();
      checkOutput("t1_rack_edge3", {31'd0, Rack}, 32'd1);
      checkOutput("t1_valid_capture", {31'd0, out_valid}, 32'd0);
      tick();
      checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("t1_data", {24'd0, out_data}, 32'hA5);
      checkOutput("t1_level", {29'd0, level}, 32'd1);
      applyStimulus(1'b0, 8'hA5, 1'b0);
      tick();
      tick();
      checkOutput("t1_rack_hold", {31'd0, Rack}, 32'd1);
      tick();
      checkOutput("t1_rack_fall", {31'd0, Rack}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t1_drained", {29'd0, level}, 32'd0);

      // fill the FIFO, fifth request must stall
      for (int i = 1; i <= 4; i++) begin
         w = 8'(i);
         handshake(w, goodPar(w));
      end
      checkOutput("t2_level_full", {29'd0, level}, 32'd4);
      applyStimulus(1'b1, 8'h05, goodPar(8'h05));
      for (int i = 0; i < 6; i++) tick();
      checkOutput("t2_fifth_stalled", {31'd0, Rack}, 32'd0);
      checkOutput("t2_level_still4", {29'd0, level}, 32'd4);
      checkOutput("t2_head1", {24'd0, out_data}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t2_level_after_pop", {29'd0, level}, 32'd3);
      checkOutput("t2_rack_pop_edge", {31'd0, Rack}, 32'd0);
      tick();
      checkOutput("t2_fifth_acked", {31'd0, Rack}, 32'd1);
      applyStimulus(1'b0, 8'h05, goodPar(8'h05));
      waitRack(1'b0, "t2_fifth_release");
      checkOutput("t2_level_refull", {29'd0, level}, 32'd4);
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         checkOutput("t2_drain_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("t2_drain_data", {24'd0, out_data}, 32'(i));
         tick();
      end
      out_ready = 1'b0;
      checkOutput("t2_drain_empty", {29'd0, level}, 32'd0);

      // bad parity word and error handshake
      applyStimulus(1'b1, 8'h01, 1'b0);
      waitRack(1'b1, "t3_ack_rise");
      checkOutput("t3_errcnt", {24'd0, err_count}, 32'd1);
      tick();
      checkOutput("t3_no_push", {29'd0, level}, 32'd0);
      applyStimulus(1'b0, 8'h01, 1'b0);
      tick();
      tick();
      checkOutput("t3_rack_hold", {31'd0, Rack}, 32'd1);
      tick();
      checkOutput("t3_rack_fall", {31'd0, Rack}, 32'd0);
      checkOutput("t3_ereq_not_yet", {31'd0, REreq}, 32'd0);
      tick();
      checkOutput("t3_ereq_rise", {31'd0, REreq}, 32'd1);
      REack = 1'b1;
      tick();
      tick();
      checkOutput("t3_ereq_hold", {31'd0, REreq}, 32'd1);
      tick();
      checkOutput("t3_ereq_fall", {31'd0, REreq}, 32'd0);
      REack = 1'b0;
      tick();
      tick();
      tick();
      applyStimulus(1'b1, 8'h3C, goodPar(8'h3C));
      tick();
      tick();
      tick();
      checkOutput("t3_next_ack", {31'd0, Rack}, 32'd1);
      tick();
      checkOutput("t3_next_level", {29'd0, level}, 32'd1);
      checkOutput("t3_next_data", {24'd0, out_data}, 32'h3C);
      applyStimulus(1'b0, 8'h3C, goodPar(8'h3C));
      waitRack(1'b0, "t3_next_release");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t3_drained", {29'd0, level}, 32'd0);

      // continuous traffic with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         w = 8'h10 + 8'(i);
         applyStimulus(1'b1, w, goodPar(w));
         waitRack(1'b1, "t4_ack_rise");
         tick();
         checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("t4_data", {24'd0, out_data}, {24'd0, w});
         checkOutput("t4_level", {29'd0, level}, 32'd1);
         tick();
         checkOutput("t4_popped", {29'd0, level}, 32'd0);
         applyStimulus(1'b0, w, goodPar(w));
         waitRack(1'b0, "t4_ack_fall");
      end
      out_ready = 1'b0;

      // simultaneous push and pop
      handshake(8'h77, goodPar(8'h77));
      checkOutput("t4b_level1", {29'd0, level}, 32'd1);
      applyStimulus(1'b1, 8'h88, goodPar(8'h88));
      waitRack(1'b1, "t4b_ack_rise");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t4b_level_same", {29'd0, level}, 32'd1);
      checkOutput("t4b_head", {24'd0, out_data}, 32'h88);
      applyStimulus(1'b0, 8'h88, goodPar(8'h88));
      waitRack(1'b0, "t4b_ack_fall");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t4b_drained", {29'd0, level}, 32'd0);

      // reset while in ACK with two words buffered
      handshake(8'h21, goodPar(8'h21));
      handshake(8'h42, goodPar(8'h42));
      checkOutput("t5_level2", {29'd0, level}, 32'd2);
      applyStimulus(1'b1, 8'h63, goodPar(8'h63));
      waitRack(1'b1, "t5_in_ack");
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_rack", {31'd0, Rack}, 32'd0);
      checkOutput("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("t5_rst_level", {29'd0, level}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      checkOutput("t5_rack_edge2", {31'd0, Rack}, 32'd0);
      tick();
      checkOutput("t5_reaccept", {31'd0, Rack}, 32'd1);
      tick();
      checkOutput("t5_level1", {29'd0, level}, 32'd1);
      checkOutput("t5_data", {24'd0, out_data}, 32'h63);
      applyStimulus(1'b0, 8'h63, goodPar(8'h63));
      waitRack(1'b0, "t5_release");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 256 bad words saturate the error counter
      for (int i = 0; i < 256; i++) begin
         w = 8'(i);
         applyStimulus(1'b1, w, ~goodPar(w));
         waitRack(1'b1, "t6_ack_rise");
         checkOutput("t6_errcnt", {24'd0, err_count}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
         applyStimulus(1'b0, w, ~goodPar(w));
         waitRack(1'b0, "t6_ack_fall");
         waitEreq(1'b1, "t6_ereq_rise");
         REack = 1'b1;
         waitEreq(1'b0, "t6_ereq_fall");
         REack = 1'b0;
         for (int k = 0; k < 4; k++) tick();
      end
      checkOutput("t6_saturated", {24'd0, err_count}, 32'd255);
      checkOutput("t6_no_push", {29'd0, level}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
